// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file: FSM state,
// depth derivation and lane offsets into the packed port buses.
package regfile_pkg;

    typedef enum logic {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_t;

    function automatic int calcDepth(input int addrW);
        return 1 << addrW;
    endfunction

    // Bit offset of lane `lane` in a packed bus of `laneW`-bit lanes.
    function automatic int laneLo(input int lane, input int laneW);
        return lane * laneW;
    endfunction

endpackage

// File: rtl/regfile_rd_mux.sv
// One read lane: stored value, optionally overridden by a same-cycle write,
// forced to zero for register 0 and while the clear engine is running.
module regfile_rd_mux
    import regfile_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int ADDR_W   = 5,
    parameter int N_WR     = 1,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic [ADDR_W-1:0]      rdAddr,
    input  logic [XLEN-1:0]        memData,
    input  logic [N_WR-1:0]        wrEn,
    input  logic [N_WR*ADDR_W-1:0] wrAddr,
    input  logic [N_WR*XLEN-1:0]   wrData,
    input  logic                   busy,
    output logic [XLEN-1:0]        rdData
);

    always_comb begin
        rdData = memData;
        // Ascending scan so the highest-index matching port has the last word.
        if (BYPASS != 0) begin
            for (int j = 0; j < N_WR; j++) begin
                if (wrEn[j] && (wrAddr[laneLo(j, ADDR_W) +: ADDR_W] == rdAddr)) begin
                    rdData = wrData[laneLo(j, XLEN) +: XLEN];
                end
            end
        end
        if ((ZERO_REG != 0) && (rdAddr == '0)) begin
            rdData = '0;
        end
        if (busy) begin
            rdData = '0;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with optional write-to-read bypass and a
// sequential clear engine that zeroes one entry per cycle instead of a parallel reset.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int ADDR_W   = 5,
    parameter int N_RD     = 2,
    parameter int N_WR     = 1,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_RD*ADDR_W-1:0] rd_addr,
    output logic [N_RD*XLEN-1:0]   rd_data,
    input  logic [N_WR-1:0]        wr_en,
    input  logic [N_WR*ADDR_W-1:0] wr_addr,
    input  logic [N_WR*XLEN-1:0]   wr_data,
    input  logic                   clr_req,
    output logic                   clr_busy
);

    localparam int DEPTH = calcDepth(ADDR_W);

    rf_state_t         stateReg, stateNext;
    logic [ADDR_W-1:0] cntReg, cntNext;
    logic [XLEN-1:0]   mem [DEPTH];
    logic              wrAccept;
    logic [N_WR-1:0]   wrEnEff;

    always_comb begin
        stateNext = stateReg;
        cntNext   = cntReg;
        case (stateReg)
            RF_CLEAR: begin
                cntNext = cntReg + ADDR_W'(1);
                if (cntReg == ADDR_W'(DEPTH - 1)) begin
                    stateNext = RF_IDLE;
                end
            end
            default: begin
                if (clr_req) begin
                    stateNext = RF_CLEAR;
                    cntNext   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stateReg <= RF_CLEAR;
            cntReg   <= '0;
        end else begin
            stateReg <= stateNext;
            cntReg   <= cntNext;
        end
    end

    // Reset is folded in so busy (and read masking) holds before the first edge too.
    assign clr_busy = reset || (stateReg == RF_CLEAR);
    assign wrAccept = !reset && (stateReg == RF_IDLE) && !clr_req;

    generate
        for (genvar gi = 0; gi < N_WR; gi++) begin : g_wr_en
            assign wrEnEff[gi] = wr_en[gi] && wrAccept &&
                !((ZERO_REG != 0) && (wr_addr[laneLo(gi, ADDR_W) +: ADDR_W] == '0));
        end
    endgenerate

    // Later ports are applied last, so the highest-index port wins on a collision.
    always_ff @(posedge clk) begin
        if (!reset && (stateReg == RF_CLEAR)) begin
            mem[cntReg] <= '0;
        end else begin
            for (int j = 0; j < N_WR; j++) begin
                if (wrEnEff[j]) begin
                    mem[wr_addr[laneLo(j, ADDR_W) +: ADDR_W]] <= wr_data[laneLo(j, XLEN) +: XLEN];
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N_RD; gi++) begin : g_rd
            regfile_rd_mux #(
                .XLEN     (XLEN),
                .ADDR_W   (ADDR_W),
                .N_WR     (N_WR),
                .BYPASS   (BYPASS),
                .ZERO_REG (ZERO_REG)
            ) u_rd_mux (
                .rdAddr  (rd_addr[laneLo(gi, ADDR_W) +: ADDR_W]),
                .memData (mem[rd_addr[laneLo(gi, ADDR_W) +: ADDR_W]]),
                .wrEn    (wrEnEff),
                .wrAddr  (wr_addr),
                .wrData  (wr_data),
                .busy    (clr_busy),
                .rdData  (rd_data[laneLo(gi, XLEN) +: XLEN])
            );
        end
    endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Drives a bypassing and a non-bypassing two-write-port register file with
// shared stimulus and checks both against an architectural register model.
module tb_regfile_mp;

    localparam int XLEN  = 32;
    localparam int AW    = 5;
    localparam int NRD   = 2;
    localparam int NWR   = 2;
    localparam int DEPTH = 32;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                clr_req = 1'b0;
    logic [NRD*AW-1:0]   rd_addr = '0;
    logic [NWR-1:0]      wr_en = '0;
    logic [NWR*AW-1:0]   wr_addr = '0;
    logic [NWR*XLEN-1:0] wr_data = '0;
    logic [NRD*XLEN-1:0] rdDataA, rdDataB;
    logic                busyA, busyB;

    int checks = 0;
    int errors = 0;

    // Architectural model: register contents plus cycles of clear remaining.
    logic [XLEN-1:0] refMem [DEPTH];
    int              busyLeft = 0;

    regfile_mp #(.XLEN(XLEN), .ADDR_W(AW), .N_RD(NRD), .N_WR(NWR), .BYPASS(1), .ZERO_REG(1)) dutA (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rdDataA), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .clr_req(clr_req), .clr_busy(busyA)
    );

    regfile_mp #(.XLEN(XLEN), .ADDR_W(AW), .N_RD(NRD), .N_WR(NWR), .BYPASS(0), .ZERO_REG(1)) dutB (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rdDataB), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .clr_req(clr_req), .clr_busy(busyB)
    );

    always #5 clk = ~clk;

    // Whole file reads as zero once a clear completes, and reads are masked
    // while it runs, so zeroing the model at clear start is equivalent.
    function automatic void modelStep();
        if (reset) begin
            busyLeft = DEPTH;
            for (int i = 0; i < DEPTH; i++) refMem[i] = '0;
        end else if (busyLeft > 0) begin
            busyLeft--;
        end else if (clr_req) begin
            busyLeft = DEPTH;
            for (int i = 0; i < DEPTH; i++) refMem[i] = '0;
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (wr_en[j] && (wr_addr[j*AW +: AW] != 0)) refMem[wr_addr[j*AW +: AW]] = wr_data[j*XLEN +: XLEN];
            end
        end
    endfunction

    function automatic logic [XLEN-1:0] expRead(input int k, input bit byp);
        logic [AW-1:0] a;
        a = rd_addr[k*AW +: AW];
        if (reset || (busyLeft > 0)) return '0;
        if (a == 0) return '0;
        if (byp && !clr_req) begin
            for (int j = NWR - 1; j >= 0; j--) begin
                if (wr_en[j] && (wr_addr[j*AW +: AW] == a)) return wr_data[j*XLEN +: XLEN];
            end
        end
        return refMem[a];
    endfunction

    task automatic cycle();
        @(posedge clk);
        modelStep();
        @(negedge clk);
    endtask

    task automatic setRd(input int a0, input int a1);
        rd_addr = {AW'(a1), AW'(a0)};
    endtask

    task automatic setWr(input int j, input bit en, input int a, input logic [XLEN-1:0] d);
        wr_en[j] = en;
        wr_addr[j*AW +: AW] = AW'(a);
        wr_data[j*XLEN +: XLEN] = d;
    endtask

    task automatic test_reset();
        int n;
        reset = 1'b1;
        cycle();
        cycle();
        #1;
        checks++;
        if (busyA !== 1'b1 || busyB !== 1'b1) begin
            errors++;
            $display("FAIL reset_busy got A=%b B=%b want 1", busyA, busyB);
        end
        reset = 1'b0;
        setWr(0, 1'b1, 5, 32'hDEAD);
        n = 0;
        while (busyA === 1'b1 && n < 100) begin
            setRd($urandom_range(0, 31), 5);
            #1;
            for (int k = 0; k < NRD; k++) begin
                checks++;
                if (rdDataA[k*XLEN +: XLEN] !== '0 || rdDataB[k*XLEN +: XLEN] !== '0) begin
                    errors++;
                    $display("FAIL reset_clear_read lane%0d got A=%h B=%h want 0", k, rdDataA[k*XLEN +: XLEN], rdDataB[k*XLEN +: XLEN]);
                end
            end
            checks++;
            if (busyB !== 1'b1) begin
                errors++;
                $display("FAIL reset_busyB cycle %0d got %b want 1", n, busyB);
            end
            n++;
            cycle();
        end
        checks++;
        if (n != DEPTH) begin
            errors++;
            $display("FAIL reset_busy_len got %0d want %0d", n, DEPTH);
        end
        $display("txn reset release: clr_busy high %0d cycles", n);
        wr_en = '0;
        setRd(5, 5);
        #1;
        for (int k = 0; k < NRD; k++) begin
            checks++;
            if (rdDataA[k*XLEN +: XLEN] !== '0 || rdDataB[k*XLEN +: XLEN] !== '0) begin
                errors++;
                $display("FAIL reset_x5 lane%0d got A=%h B=%h want 0", k, rdDataA[k*XLEN +: XLEN], rdDataB[k*XLEN +: XLEN]);
            end
        end
    endtask

    task automatic test_write_read();
        setWr(0, 1'b1, 3, 32'h12345678);
        cycle();
        wr_en = '0;
        setRd(3, 3);
        #1;
        $display("txn write x3=12345678 read A=%h B=%h", rdDataA, rdDataB);
        for (int k = 0; k < NRD; k++) begin
            checks++;
            if (rdDataA[k*XLEN +: XLEN] !== 32'h12345678 || rdDataB[k*XLEN +: XLEN] !== 32'h12345678) begin
                errors++;
                $display("FAIL write_read_x3 lane%0d got A=%h B=%h want 12345678", k, rdDataA[k*XLEN +: XLEN], rdDataB[k*XLEN +: XLEN]);
            end
        end
        setWr(0, 1'b1, 0, 32'hFFFFFFFF);
        cycle();
        wr_en = '0;
        setRd(0, 0);
        #1;
        $display("txn write x0=ffffffff read A=%h B=%h", rdDataA, rdDataB);
        for (int k = 0; k < NRD; k++) begin
            checks++;
            if (rdDataA[k*XLEN +: XLEN] !== '0 || rdDataB[k*XLEN +: XLEN] !== '0) begin
                errors++;
                $display("FAIL zero_reg lane%0d got A=%h B=%h want 0", k, rdDataA[k*XLEN +: XLEN], rdDataB[k*XLEN +: XLEN]);
            end
        end
    endtask

    task automatic test_bypass();
        setWr(0, 1'b1, 7, 32'h11111111);
        cycle();
        setWr(0, 1'b1, 7, 32'hA5A5A5A5);
        setRd(7, 7);
        #1;
        $display("txn write+read x7=a5a5a5a5 same cycle A=%h B=%h", rdDataA, rdDataB);
        for (int k = 0; k < NRD; k++) begin
            checks++;
            if (rdDataA[k*XLEN +: XLEN] !== 32'hA5A5A5A5) begin
                errors++;
                $display("FAIL bypass_on lane%0d got %h want a5a5a5a5", k, rdDataA[k*XLEN +: XLEN]);
            end
            checks++;
            if (rdDataB[k*XLEN +: XLEN] !== 32'h11111111) begin
                errors++;
                $display("FAIL bypass_off lane%0d got %h want 11111111", k, rdDataB[k*XLEN +: XLEN]);
            end
        end
        cycle();
        wr_en = '0;
        #1;
        for (int k = 0; k < NRD; k++) begin
            checks++;
            if (rdDataA[k*XLEN +: XLEN] !== 32'hA5A5A5A5 || rdDataB[k*XLEN +: XLEN] !== 32'hA5A5A5A5) begin
                errors++;
                $display("FAIL bypass_next lane%0d got A=%h B=%h want a5a5a5a5", k, rdDataA[k*XLEN +: XLEN], rdDataB[k*XLEN +: XLEN]);
            end
        end
    endtask

    task automatic test_dual_write();
        setWr(0, 1'b1, 9, 32'h1);
        setWr(1, 1'b1, 9, 32'h2);
        setRd(9, 9);
        #1;
        $display("txn dual write x9 p0=1 p1=2 same-cycle read A=%h B=%h", rdDataA, rdDataB);
        for (int k = 0; k < NRD; k++) begin
            checks++;
            if (rdDataA[k*XLEN +: XLEN] !== 32'h2 || rdDataB[k*XLEN +: XLEN] !== expRead(k, 1'b0)) begin
                errors++;
                $display("FAIL dual_bypass lane%0d got A=%h B=%h want A=2 B=%h", k, rdDataA[k*XLEN +: XLEN], rdDataB[k*XLEN +: XLEN], expRead(k, 1'b0));
            end
        end
        cycle();
        wr_en = '0;
        #1;
        for (int k = 0; k < NRD; k++) begin
            checks++;
            if (rdDataA[k*XLEN +: XLEN] !== 32'h2 || rdDataB[k*XLEN +: XLEN] !== 32'h2) begin
                errors++;
                $display("FAIL dual_write lane%0d got A=%h B=%h want 2", k, rdDataA[k*XLEN +: XLEN], rdDataB[k*XLEN +: XLEN]);
            end
        end
    endtask

    task automatic test_random(input int iters);
        int hi;
        for (int i = 0; i < iters; i++) begin
            hi = ($urandom_range(0, 1) == 1) ? 3 : 31;
            wr_en = NWR'($urandom_range(0, 3));
            for (int j = 0; j < NWR; j++) begin
                wr_addr[j*AW +: AW] = AW'($urandom_range(0, hi));
                wr_data[j*XLEN +: XLEN] = $urandom;
            end
            setRd($urandom_range(0, hi), $urandom_range(0, hi));
            #1;
            $display("txn rand %0d we=%b wa=%h rd=%h A=%h B=%h", i, wr_en, wr_addr, rd_addr, rdDataA, rdDataB);
            for (int k = 0; k < NRD; k++) begin
                checks++;
                if (rdDataA[k*XLEN +: XLEN] !== expRead(k, 1'b1) || rdDataB[k*XLEN +: XLEN] !== expRead(k, 1'b0)) begin
                    errors++;
                    $display("FAIL random lane%0d got A=%h B=%h want A=%h B=%h", k,
                             rdDataA[k*XLEN +: XLEN], rdDataB[k*XLEN +: XLEN], expRead(k, 1'b1), expRead(k, 1'b0));
                end
            end
            cycle();
        end
        wr_en = '0;
    endtask

    task automatic test_clear();
        int n;
        for (int r = 1; r <= 31; r += 2) begin
            setWr(0, 1'b1, r, 32'hC0000000 | r);
            setWr(1, (r + 1) <= 31, r + 1, 32'hC0000000 | (r + 1));
            cycle();
        end
        wr_en = '0;
        clr_req = 1'b1;
        setWr(0, 1'b1, 4, 32'h55);
        #1;
        checks++;
        if (busyA !== 1'b0 || busyB !== 1'b0) begin
            errors++;
            $display("FAIL clear_req_cycle_busy got A=%b B=%b want 0", busyA, busyB);
        end
        cycle();
        clr_req = 1'b0;
        wr_en = '0;
        n = 0;
        while (busyA === 1'b1 && n < 100) begin
            clr_req = (n == 10);
            setRd($urandom_range(1, 31), 4);
            #1;
            for (int k = 0; k < NRD; k++) begin
                checks++;
                if (rdDataA[k*XLEN +: XLEN] !== '0 || rdDataB[k*XLEN +: XLEN] !== '0) begin
                    errors++;
                    $display("FAIL clear_busy_read lane%0d got A=%h B=%h want 0", k, rdDataA[k*XLEN +: XLEN], rdDataB[k*XLEN +: XLEN]);
                end
            end
            n++;
            cycle();
        end
        clr_req = 1'b0;
        checks++;
        if (n != DEPTH) begin
            errors++;
            $display("FAIL clear_busy_len got %0d want %0d", n, DEPTH);
        end
        $display("txn clr_req: clr_busy high %0d cycles", n);
        for (int r = 0; r < DEPTH; r += 2) begin
            setRd(r, r + 1);
            #1;
            for (int k = 0; k < NRD; k++) begin
                checks++;
                if (rdDataA[k*XLEN +: XLEN] !== '0 || rdDataB[k*XLEN +: XLEN] !== '0) begin
                    errors++;
                    $display("FAIL clear_result x%0d got A=%h B=%h want 0", r + k, rdDataA[k*XLEN +: XLEN], rdDataB[k*XLEN +: XLEN]);
                end
            end
            cycle();
        end
    endtask

    task automatic test_reset_midclear();
        int n;
        clr_req = 1'b1;
        cycle();
        clr_req = 1'b0;
        repeat (17) cycle();
        reset = 1'b1;
        #1;
        checks++;
        if (busyA !== 1'b1 || busyB !== 1'b1) begin
            errors++;
            $display("FAIL midclear_reset_busy got A=%b B=%b want 1", busyA, busyB);
        end
        cycle();
        reset = 1'b0;
        n = 0;
        while (busyA === 1'b1 && n < 100) begin
            n++;
            cycle();
        end
        checks++;
        if (n != DEPTH || busyB !== 1'b0) begin
            errors++;
            $display("FAIL midclear_busy_len got %0d (B busy=%b) want %0d", n, busyB, DEPTH);
        end
        $display("txn reset at cnt=17: clr_busy high %0d cycles after release", n);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) refMem[i] = '0;
        test_reset();
        test_write_read();
        test_bypass();
        test_dual_write();
        test_random(150);
        test_clear();
        test_reset_midclear();
        test_random(60);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
